// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller.
// State encodings are fixed so the bench and any debug tooling agree on them.
package data_memory_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
interface data_memory_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_memory_ctrl_storage.sv
// DEPTH x DATA_W storage array with per-byte write mask and a registered read port.
// Contents and read register are intentionally not reset.
module data_memory_ctrl_storage
    import data_memory_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                          clock,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [IDX_W-1:0]              idx,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [be_width(DATA_W)-1:0]   be,
    output logic [DATA_W-1:0]             rdata
);
    localparam int BE_W = be_width(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) rdata <= mem[idx];
    end
endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller for the MEM stage: one transaction at a time, byte-enable writes,
// configurable read latency, range error flag and response back-pressure.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    data_memory_ctrl_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic               err_q;
    logic               rd_ok_q;
    logic [DATA_W-1:0]  store_rdata;

    logic addr_err;
    logic accept;
    logic wr_en;
    logic rd_en;

    assign addr_err = {1'b0, bus.req_addr} >= DEPTH_EXT;
    assign accept   = bus.req_valid && req_ready_q;
    assign wr_en    = accept &&  bus.req_write && !addr_err;
    assign rd_en    = accept && !bus.req_write && !addr_err;

    data_memory_ctrl_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_storage (
        .clock (clock),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .idx   (bus.req_addr[IDX_W-1:0]),
        .wdata (bus.req_wdata),
        .be    (bus.req_be),
        .rdata (store_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        err_q       <= addr_err;
                        rd_ok_q     <= !bus.req_write && !addr_err;
                        req_ready_q <= 1'b0;
                        if (bus.req_write || READ_LATENCY == 1) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(READ_LATENCY - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state        <= ST_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state        <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        err_q        <= 1'b0;
                        rd_ok_q      <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    err_q        <= 1'b0;
                    rd_ok_q      <= 1'b0;
                end
            endcase
        end
    end

    // The storage read register only moves on an accepted read, so it is stable through RESP.
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = err_q;
    assign bus.resp_rdata = (rd_ok_q && resp_valid_q) ? store_rdata : '0;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (latency 1 / depth 256 and latency 3 / depth 200)
// share one stimulus stream and are checked every cycle against a transaction-level model.
module tb_data_memory_ctrl;
    import data_memory_ctrl_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int RL_A  = 1;
    localparam int RL_B  = 3;
    localparam int DEP_A = 256;
    localparam int DEP_B = 200;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          req_valid  = 1'b0;
    logic          req_write  = 1'b0;
    logic [15:0]   req_addr   = '0;
    logic [15:0]   req_wdata  = '0;
    logic [1:0]    req_be     = '0;
    logic          resp_ready = 1'b0;
    bit            hold_rr    = 1'b0;

    data_memory_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ia ();
    data_memory_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ib ();

    assign ia.req_valid  = req_valid;
    assign ia.req_write  = req_write;
    assign ia.req_addr   = req_addr;
    assign ia.req_wdata  = req_wdata;
    assign ia.req_be     = req_be;
    assign ia.resp_ready = resp_ready;
    assign ib.req_valid  = req_valid;
    assign ib.req_write  = req_write;
    assign ib.req_addr   = req_addr;
    assign ib.req_wdata  = req_wdata;
    assign ib.req_be     = req_be;
    assign ib.resp_ready = resp_ready;

    data_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP_A), .READ_LATENCY(RL_A)) dut_a (
        .clock (clock), .reset_n (reset_n), .bus (ia));
    data_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP_B), .READ_LATENCY(RL_B)) dut_b (
        .clock (clock), .reset_n (reset_n), .bus (ib));

    // Transaction-level model: an in-flight flag, the accept cycle and the required latency.
    int          cyc = 0;
    bit          busy   [2] = '{0, 0};
    int          acc    [2] = '{0, 0};
    int          lat    [2] = '{1, 1};
    int          lat_of [2] = '{RL_A, RL_B};
    int          depth  [2] = '{DEP_A, DEP_B};
    logic [15:0] exp_rd [2];
    bit          exp_er [2];
    logic [15:0] mem    [2][256];
    logic [15:0] last_rd[2];
    bit          last_er[2];
    int          rise   [2];
    bit          prev_v [2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;

    always @(posedge clock) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                if (busy[d]) begin
                    if (cyc - acc[d] >= lat[d] && resp_ready) busy[d] = 1'b0;
                end else if (req_valid) begin
                    busy[d]   = 1'b1;
                    acc[d]    = cyc;
                    lat[d]    = req_write ? 1 : lat_of[d];
                    exp_er[d] = int'(req_addr) >= depth[d];
                    exp_rd[d] = '0;
                    if (!exp_er[d]) begin
                        if (req_write) begin
                            for (int b = 0; b < 2; b++)
                                if (req_be[b]) mem[d][req_addr[7:0]][8*b +: 8] = req_wdata[8*b +: 8];
                        end else begin
                            exp_rd[d] = mem[d][req_addr[7:0]];
                        end
                    end
                end
            end
            cyc++;
        end
    end

    always @(negedge reset_n) begin
        busy[0] = 1'b0;
        busy[1] = 1'b0;
    end

    always @(negedge clock) begin
        if (hold_rr) resp_ready = 1'b0;
        else         resp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input int d, input logic rdy, input logic vld,
                       input logic [15:0] rd, input logic er);
        bit ev;
        ev = busy[d] && (cyc - acc[d] >= lat[d]);
        checks++;
        if (rdy !== !busy[d]) begin
            errors++;
            $display("FAIL req_ready[%0d] t=%0t got %b expected %b", d, $time, rdy, !busy[d]);
        end
        checks++;
        if (vld !== ev) begin
            errors++;
            $display("FAIL resp_valid[%0d] t=%0t got %b expected %b", d, $time, vld, ev);
        end
        if (ev) begin
            checks++;
            if (rd !== exp_rd[d]) begin
                errors++;
                $display("FAIL resp_rdata[%0d] t=%0t got %h expected %h", d, $time, rd, exp_rd[d]);
            end
            checks++;
            if (er !== exp_er[d]) begin
                errors++;
                $display("FAIL resp_error[%0d] t=%0t got %b expected %b", d, $time, er, exp_er[d]);
            end
            last_rd[d] = rd;
            last_er[d] = er;
            if (!prev_v[d]) rise[d] = cyc - acc[d];
        end
        prev_v[d] = ev;
    endtask

    always @(negedge clock) begin
        chk(0, ia.req_ready, ia.resp_valid, ia.resp_rdata, ia.resp_error);
        chk(1, ib.req_ready, ib.resp_valid, ib.resp_rdata, ib.resp_error);
    end

    task automatic expect_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while ((busy[0] || busy[1]) && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL idle_timeout got busy expected idle within 300 cycles");
        end
    endtask

    task automatic issue(input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be);
        wait_idle();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        req_be    = 2'($urandom);
    endtask

    task automatic txn(input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be);
        issue(wr, addr, wdata, be);
        wait_idle();
    endtask

    logic [15:0] init0;

    initial begin
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        for (int a = 0; a < 256; a++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (a == 0) init0 = v;
            txn(1'b1, 16'(a), v, 2'b11);
        end

        // Plain write then read back.
        txn(1'b1, 16'd1, 16'd16, 2'b11);
        expect_val("wr_latency_a", rise[0], 1);
        expect_val("wr_error_a", int'(last_er[0]), 0);
        txn(1'b0, 16'd1, 16'h0, 2'b00);
        expect_val("rd_latency_a", rise[0], 1);
        expect_val("rd_data_a", int'(last_rd[0]), 16);

        // Byte-enable merge.
        txn(1'b1, 16'd5, 16'hABCD, 2'b11);
        txn(1'b1, 16'd5, 16'h1234, 2'b01);
        txn(1'b0, 16'd5, 16'h0, 2'b00);
        expect_val("be_merge_a", int'(last_rd[0]), 16'hAB34);
        expect_val("be_merge_b", int'(last_rd[1]), 16'hAB34);

        // Latency 3 with response held off.
        hold_rr = 1'b1;
        issue(1'b0, 16'd5, 16'h0, 2'b00);
        repeat (6) @(negedge clock);
        expect_val("bp_latency_b", rise[1], 3);
        expect_val("bp_data_b", int'(last_rd[1]), 16'hAB34);
        expect_val("bp_ready_b", int'(ib.req_ready), 0);
        expect_val("bp_valid_b", int'(ib.resp_valid), 1);
        hold_rr = 1'b0;
        wait_idle();

        // Out-of-range accesses.
        txn(1'b1, 16'd256, 16'hFFFF, 2'b11);
        expect_val("err_wr_a", int'(last_er[0]), 1);
        expect_val("err_wr_b", int'(last_er[1]), 1);
        txn(1'b0, 16'd256, 16'h0, 2'b00);
        expect_val("err_rd_a", int'(last_er[0]), 1);
        expect_val("err_rd_data_b", int'(last_rd[1]), 0);
        expect_val("err_rd_latency_b", rise[1], 3);
        txn(1'b0, 16'd0, 16'h0, 2'b00);
        expect_val("addr0_intact_a", int'(last_rd[0]), int'(init0));
        txn(1'b0, 16'd200, 16'h0, 2'b00);
        expect_val("depth_edge_a", int'(last_er[0]), 0);
        expect_val("depth_edge_b", int'(last_er[1]), 1);
        txn(1'b0, 16'hFFFF, 16'h0, 2'b00);
        expect_val("top_addr_b", int'(last_er[1]), 1);

        // Reset while instance b waits on its read; its write earlier stays in storage.
        txn(1'b1, 16'd7, 16'h5A5A, 2'b11);
        issue(1'b0, 16'd7, 16'h0, 2'b00);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        expect_val("rst_ready_b", int'(ib.req_ready), 1);
        expect_val("rst_valid_b", int'(ib.resp_valid), 0);
        expect_val("rst_valid_a", int'(ia.resp_valid), 0);
        expect_val("rst_err_a", int'(ia.resp_error), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        txn(1'b0, 16'd7, 16'h0, 2'b00);
        expect_val("after_rst_b", int'(last_rd[1]), 16'h5A5A);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(200, 65535))
                                             : 16'($urandom_range(0, 255));
            txn(1'($urandom), a, 16'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end
endmodule
